// File: rtl/counter_overflow_sched_pkg.sv
// Shared types and helpers for the counter overflow scheduler.
package counter_overflow_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam int DEF_W     = 8;
  localparam int DEF_N_REQ = 4;

  // Start value that makes a w-bit up-counter wrap after `period` ticks; 0 means 2^w.
  function automatic logic [31:0] load_value(input logic [31:0] period, input int w);
    logic [31:0] mask;
    mask = (32'd1 << w) - 32'd1;
    return (32'd0 - period) & mask;
  endfunction

endpackage

// File: rtl/counter_overflow_sched_if.sv
// Client and counter-datapath signals of the scheduler, bundled for port use.
interface counter_overflow_sched_if
  import counter_overflow_sched_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int W     = DEF_W
);
  logic [N_REQ-1:0]   req;
  logic [N_REQ*W-1:0] period;
  logic [N_REQ-1:0]   grant;
  logic [N_REQ-1:0]   done;
  logic               err;
  logic               busy;
  logic [W-1:0]       cnt_d;
  logic               cnt_load;
  logic               cnt_en;
  logic               cnt_overflow;

  modport master (
    output req, period, cnt_overflow,
    input  grant, done, err, busy, cnt_d, cnt_load, cnt_en
  );

  modport slave (
    input  req, period, cnt_overflow,
    output grant, done, err, busy, cnt_d, cnt_load, cnt_en
  );
endinterface

// File: rtl/counter_overflow_sched_rr_arbiter.sv
// Combinational round-robin pick: first active request at or above ptr, wrapping.
module counter_overflow_sched_rr_arbiter #(
  parameter int  N_REQ = 4,
  localparam int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IW-1:0]    idx,
  output logic             vld
);

  int cand;

  always_comb begin
    gnt  = '0;
    idx  = '0;
    vld  = 1'b0;
    cand = 0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = (int'(ptr) + k) % N_REQ;
      if (!vld && req[IW'(cand)]) begin
        vld             = 1'b1;
        idx             = IW'(cand);
        gnt[IW'(cand)]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/counter_overflow_sched.sv
// Shares one loadable overflow counter among N_REQ one-shot interval requesters.
module counter_overflow_sched
  import counter_overflow_sched_pkg::*;
#(
  parameter int N_REQ    = DEF_N_REQ,
  parameter int W        = DEF_W,
  parameter int WD_LIMIT = 2**W + 2
) (
  input logic                      clk,
  input logic                      rst_n,
  counter_overflow_sched_if.slave  bus
);

  localparam int IW  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int WDW = $clog2(WD_LIMIT + 1);

  state_e             state_q, state_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic [WDW-1:0]     wd_q, wd_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [N_REQ-1:0]   done_q, done_d;
  logic               err_q, err_d;
  logic               busy_q, busy_d;
  logic               cnt_load_q, cnt_load_d;
  logic [W-1:0]       cnt_d_q, cnt_d_d;

  logic [N_REQ-1:0]   win_gnt;
  logic [IW-1:0]      win_idx;
  logic               win_vld;
  logic [W-1:0]       win_period;
  logic               owner_req;
  logic               wd_hit;

  counter_overflow_sched_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req (bus.req),
    .ptr (ptr_q),
    .gnt (win_gnt),
    .idx (win_idx),
    .vld (win_vld)
  );

  function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] i);
    return (32'(i) == N_REQ - 1) ? '0 : i + 1'b1;
  endfunction

  assign win_period = bus.period[win_idx*W +: W];
  assign owner_req  = bus.req[idx_q];
  assign wd_hit     = (wd_q == WDW'(WD_LIMIT - 1));

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    ptr_d      = ptr_q;
    wd_d       = wd_q;
    grant_d    = grant_q;
    done_d     = '0;
    err_d      = 1'b0;
    cnt_load_d = 1'b0;
    cnt_d_d    = cnt_d_q;
    case (state_q)
      ST_IDLE: begin
        if (win_vld) begin
          state_d    = ST_LOAD;
          idx_d      = win_idx;
          grant_d    = win_gnt;
          cnt_load_d = 1'b1;
          cnt_d_d    = W'(load_value(32'(win_period), W));
          wd_d       = '0;
        end
      end
      ST_LOAD: begin
        if (!owner_req) begin
          state_d = ST_IDLE;
          grant_d = '0;
          ptr_d   = next_ptr(idx_q);
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        wd_d = wd_q + 1'b1;
        // Withdrawal beats a coincident overflow or watchdog expiry.
        if (!owner_req) begin
          state_d = ST_IDLE;
          grant_d = '0;
          ptr_d   = next_ptr(idx_q);
        end else if (bus.cnt_overflow) begin
          state_d = ST_DONE;
          done_d  = grant_q;
        end else if (wd_hit) begin
          state_d = ST_DONE;
          done_d  = grant_q;
          err_d   = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        grant_d = '0;
        ptr_d   = next_ptr(idx_q);
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      ptr_q      <= '0;
      wd_q       <= '0;
      grant_q    <= '0;
      done_q     <= '0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      cnt_load_q <= 1'b0;
      cnt_d_q    <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      ptr_q      <= ptr_d;
      wd_q       <= wd_d;
      grant_q    <= grant_d;
      done_q     <= done_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      cnt_load_q <= cnt_load_d;
      cnt_d_q    <= cnt_d_d;
    end
  end

  assign bus.grant    = grant_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign bus.busy     = busy_q;
  assign bus.cnt_load = cnt_load_q;
  assign bus.cnt_d    = cnt_d_q;
  assign bus.cnt_en   = (state_q == ST_RUN) && !bus.cnt_overflow && owner_req;

endmodule

// File: tb/tb_counter_overflow_sched.sv
// Directed bench for counter_overflow_sched with a behavioural 8-bit overflow counter.
module tb_counter_overflow_sched;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int WD = 2**W + 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  counter_overflow_sched_if #(.N_REQ(N), .W(W)) bus();

  logic [7:0] m_cnt;
  logic       m_ovf;
  logic       model_on;
  logic       inj_ovf;

  assign bus.cnt_overflow = m_ovf | inj_ovf;

  // Counter datapath model: loads on cnt_load, counts on cnt_en, registered wrap pulse.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt <= 8'h00;
      m_ovf <= 1'b0;
    end else if (bus.cnt_load) begin
      m_cnt <= bus.cnt_d;
      m_ovf <= 1'b0;
    end else if (bus.cnt_en) begin
      m_cnt <= m_cnt + 8'h01;
      m_ovf <= model_on && (m_cnt == 8'hFF);
    end else begin
      m_ovf <= 1'b0;
    end
  end

  counter_overflow_sched #(.N_REQ(N), .W(W), .WD_LIMIT(WD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic int oh2i(input logic [3:0] g);
    for (int i = 0; i < 4; i++) if (g[i]) return i;
    return -1;
  endfunction

  typedef struct {
    int         idx;
    logic [7:0] per;
    logic [7:0] exp_ld;
    int         exp_done;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #200000;
    $display("FAIL tb_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{idx: 0, per: 8'd4,   exp_ld: 8'hFC, exp_done: 7};
    vecs[1] = '{idx: 2, per: 8'd0,   exp_ld: 8'h00, exp_done: 259};
    vecs[2] = '{idx: 2, per: 8'd1,   exp_ld: 8'hFF, exp_done: 4};
    vecs[3] = '{idx: 1, per: 8'd10,  exp_ld: 8'hF6, exp_done: 13};
    vecs[4] = '{idx: 3, per: 8'd255, exp_ld: 8'h01, exp_done: 258};

    bus.req    = '0;
    bus.period = '0;
    model_on   = 1'b1;
    inj_ovf    = 1'b0;

    #12;
    check("rst_grant",    bus.grant,    0);
    check("rst_done",     bus.done,     0);
    check("rst_err",      bus.err,      0);
    check("rst_busy",     bus.busy,     0);
    check("rst_cnt_d",    bus.cnt_d,    0);
    check("rst_cnt_load", bus.cnt_load, 0);
    check("rst_cnt_en",   bus.cnt_en,   0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Single-request vectors: load value at cycle 1, done at P+3, idle afterwards.
    for (int v = 0; v < 5; v++) begin
      int         dc;
      logic [3:0] oh;
      oh = 4'b0001 << vecs[v].idx;
      bus.period = '0;
      bus.period[vecs[v].idx*8 +: 8] = vecs[v].per;
      bus.req = oh;
      cyc = 0;
      tick();
      check("vec_load_grant",  bus.grant,    oh);
      check("vec_load_strobe", bus.cnt_load, 1);
      check("vec_load_value",  bus.cnt_d,    vecs[v].exp_ld);
      dc = -1;
      while (dc < 0 && cyc < vecs[v].exp_done + 5) begin
        tick();
        if (bus.done != 0) dc = cyc;
      end
      check("vec_done_cycle", dc,       vecs[v].exp_done);
      check("vec_done_owner", bus.done, oh);
      check("vec_done_err",   bus.err,  0);
      check("vec_done_grant", bus.grant, oh);
      bus.req = '0;
      tick();
      check("vec_idle_busy",  bus.busy,  0);
      check("vec_idle_grant", bus.grant, 0);
      check("vec_idle_done",  bus.done,  0);
    end

    // Overflow pulse while idle must not start anything.
    inj_ovf = 1'b1;
    tick();
    inj_ovf = 1'b0;
    tick();
    check("idle_ovf_busy", bus.busy, 0);
    check("idle_ovf_done", bus.done, 0);

    // Round-robin fairness with all four requesting.
    begin : fair
      int         ng;
      int         nd;
      int         gseq[5];
      logic [3:0] prev_g;
      logic [3:0] last_g;
      ng = 0;
      nd = 0;
      prev_g = '0;
      last_g = '0;
      for (int k = 0; k < 5; k++) gseq[k] = -1;
      bus.period = {4{8'd2}};
      bus.req    = 4'b1111;
      for (int c = 0; c < 200; c++) begin
        tick();
        if (bus.grant != 0 && prev_g == 0) begin
          if (ng < 5) gseq[ng] = oh2i(bus.grant);
          ng++;
          last_g = bus.grant;
        end
        if (bus.done != 0) begin
          check("fair_done_owner", bus.done, last_g);
          nd++;
        end
        prev_g = bus.grant;
        if (nd == 5) break;
      end
      bus.req = '0;
      check("fair_grant0", gseq[0], 0);
      check("fair_grant1", gseq[1], 1);
      check("fair_grant2", gseq[2], 2);
      check("fair_grant3", gseq[3], 3);
      check("fair_grant4", gseq[4], 0);
      check("fair_ndone",  nd, 5);
      tick();
      check("fair_idle_busy", bus.busy, 0);
    end

    // Withdrawal of requester 1 during RUN; requester 2 is next.
    begin : withdraw
      int   dc;
      logic seen_d1;
      seen_d1 = 1'b0;
      bus.period = '0;
      bus.period[1*8 +: 8] = 8'd100;
      bus.period[2*8 +: 8] = 8'd3;
      bus.req = 4'b0110;
      cyc = 0;
      tick();
      check("wdr_grant1", bus.grant, 4'b0010);
      tick();
      tick();
      tick();
      check("wdr_en_before", bus.cnt_en, 1);
      bus.req = 4'b0100;
      #1;
      check("wdr_en_drop", bus.cnt_en, 0);
      tick();
      check("wdr_idle_busy",  bus.busy,  0);
      check("wdr_idle_grant", bus.grant, 0);
      check("wdr_idle_done",  bus.done,  0);
      check("wdr_idle_err",   bus.err,   0);
      tick();
      check("wdr_next_grant", bus.grant, 4'b0100);
      dc = -1;
      for (int c = 0; c < 20 && dc < 0; c++) begin
        tick();
        if (bus.done[1]) seen_d1 = 1'b1;
        if (bus.done != 0) dc = c;
      end
      check("wdr_no_done1",   seen_d1,  0);
      check("wdr_done2",      bus.done, 4'b0100);
      bus.req = '0;
      tick();
    end

    // Watchdog: counter never reports overflow.
    begin : wdog
      int dc;
      model_on = 1'b0;
      bus.period = '0;
      bus.period[0 +: 8] = 8'd5;
      bus.req = 4'b0001;
      cyc = 0;
      tick();
      check("wdog_grant", bus.grant, 4'b0001);
      dc = -1;
      while (dc < 0 && cyc < WD + 10) begin
        tick();
        if (bus.done != 0) dc = cyc;
      end
      check("wdog_done",   bus.done, 4'b0001);
      check("wdog_err",    bus.err,  1);
      check("wdog_lat_ok", (dc >= WD + 2) && (dc <= WD + 3), 1);
      bus.req = '0;
      tick();
      check("wdog_err_pulse", bus.err,  0);
      check("wdog_done_off",  bus.done, 0);
      check("wdog_busy_off",  bus.busy, 0);
      model_on = 1'b1;
    end

    // Asynchronous reset in the middle of RUN.
    begin : areset
      int dc;
      bus.period = '0;
      bus.period[1*8 +: 8] = 8'd50;
      bus.req = 4'b0010;
      tick();
      tick();
      tick();
      check("arst_busy_before", bus.busy, 1);
      #3;
      rst_n = 1'b0;
      #1;
      check("arst_grant",    bus.grant,    0);
      check("arst_done",     bus.done,     0);
      check("arst_err",      bus.err,      0);
      check("arst_busy",     bus.busy,     0);
      check("arst_cnt_d",    bus.cnt_d,    0);
      check("arst_cnt_load", bus.cnt_load, 0);
      check("arst_cnt_en",   bus.cnt_en,   0);
      bus.req = 4'b1000;
      bus.period[3*8 +: 8] = 8'd3;
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check("arst_first_grant", bus.grant, 4'b1000);
      dc = -1;
      for (int c = 0; c < 20 && dc < 0; c++) begin
        tick();
        if (bus.done != 0) dc = c;
      end
      check("arst_done3", bus.done, 4'b1000);
      bus.req = '0;
      tick();
      check("arst_idle", bus.busy, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/counter_overflow_sched.md
Name: counter_overflow_sched

Overview:
Round-robin scheduler that shares one 8-bit loadable overflow counter between N_REQ requesters, each asking for a one-shot interval of P counter ticks. It arbitrates, loads the counter with 2^W-P, enables it, waits for the overflow pulse, then returns a done pulse to the winning requester. It sits between the timer clients and the single counter_overflow datapath instance.

Parameters:
N_REQ, 4, number of requesters (2..8)
W, 8, counter/period width; must match the counter datapath
WD_LIMIT, 2**W+2, watchdog cycles allowed in RUN before declaring error

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req  in  N_REQ  level request per requester; held until done or withdrawn
period  in  N_REQ*W  flattened periods, requester i at [i*W +: W]; 0 means 2^W ticks
grant  out  N_REQ  one-hot owner of the counter, registered
done  out  N_REQ  one-cycle completion pulse to the owner, registered
err  out  1  one-cycle pulse coincident with done when the watchdog fired
busy  out  1  high whenever state != IDLE
cnt_d  out  W  load value to the counter, registered
cnt_load  out  1  counter load strobe, one cycle
cnt_en  out  1  counter increment enable
cnt_overflow  in  1  counter pulse, one cycle, registered, after the count wraps from all-ones to 0

Behaviour:
- Reset (async, rst_n=0): state IDLE; grant=0, done=0, err=0, busy=0, cnt_d=0, cnt_load=0, cnt_en=0; rr pointer=0; watchdog=0.
- FSM IDLE -> LOAD -> RUN -> DONE -> IDLE.
- IDLE: if |req, the round-robin winner is chosen. Search starts at the rr pointer and goes upward, wrapping. The winner's index and period are latched. Next state LOAD.
- LOAD (1 cycle): grant[idx]=1, cnt_load=1, cnt_d = 2^W - period (mod 2^W), so period 0 loads 0. Next state RUN.
- RUN: grant held. cnt_en = (state==RUN) && !cnt_overflow; this is the only combinational output. The watchdog increments every cycle.
  - On cnt_overflow=1, go to DONE.
  - If the watchdog reaches WD_LIMIT, go to DONE with err flagged.
- DONE (1 cycle): done[idx]=1, err=flag, grant still asserted. The rr pointer becomes (idx+1) mod N_REQ. Next state IDLE, where grant drops.
- Latency, with a counter that loads on cnt_load and increments on cnt_en: req sampled in IDLE at cycle 0 -> LOAD cycle 1 -> RUN cycles 2..P+2 -> done at cycle P+3.
- Back-to-back: the next grant cannot start before the cycle after DONE. The minimum gap between grants is 1 idle cycle.
- Withdrawal: if req[idx] falls in LOAD or RUN:
  - cnt_en drops in the same cycle; return to IDLE next cycle.
  - No done, no err; rr pointer advances past idx.
- Period changes after the latch are ignored until the next grant.
- cnt_overflow outside RUN is ignored and must not affect state.
- Reset mid-operation: immediate return to reset values. No done is emitted.
- At most one grant/done bit is ever set; done is only ever set for the granted index.

Decomposition:
- Package counter_overflow_sched_pkg:
  - state enum (IDLE, LOAD, RUN, DONE);
  - default W and N_REQ localparams;
  - function load_value(period) returning 2^W-period.
- Sub-module rr_arbiter (req, ptr -> one-hot grant, index, valid), combinational, parameterised by N_REQ.

Test Plan:
- Single request: req[0]=1, period[0]=4 at cycle 0 -> cnt_load=1 with cnt_d=8'hFC at cycle 1; done[0] pulses at cycle 7; err=0; busy low from cycle 8.
- Period 0 and 1: period[2]=0 -> cnt_d=8'h00, done at cycle 259. period[2]=1 -> cnt_d=8'hFF, done at cycle 4.
- Round-robin fairness: req=4'b1111 held, all periods=2:
  - grants follow 0,1,2,3,0 in order;
  - each done follows its grant;
  - no requester is granted twice before all four have been served.
- Withdrawal: req[1] dropped during RUN -> cnt_en=0 the same cycle, IDLE next cycle, done[1] never pulses, and the next grant goes to index 2 if it is requesting.
- Watchdog: the counter model never asserts overflow -> after WD_LIMIT RUN cycles, done[idx]=1 and err=1 for one cycle, then IDLE.
- Async reset: assert rst_n=0 mid-RUN, off the clock edge -> all outputs zero immediately. After release with req[3]=1, the first grant is to requester 3.
